// File: rtl/vector_permute_seq_pkg.sv
`default_nettype none
// =============================================================================
// Module : vector_permute_seq_pkg -- shared types for the permute sequencer
// Rev    : 1.0  initial release
// =============================================================================
package vector_permute_seq_pkg;

  localparam int C_NUM_ELEMS  = 8;
  localparam int C_ELEM_SIZE  = 16;
  localparam int C_REG_ADDR_W = 5;

  typedef enum logic [2:0] {
    PERM_PACK,
    PERM_SPLAT,
    PERM_SPLATB,
    PERM_SHIFT,
    PERM_SHIFTB,
    PERM_SELECT
  } Permute_op;

  typedef enum logic [1:0] {
    MODE_UPPER,
    MODE_LOWER,
    MODE_LEFT,
    MODE_RIGHT
  } Permute_mode;

  typedef enum logic [2:0] {
    FXV_COND_EQ,
    FXV_COND_NE,
    FXV_COND_LT,
    FXV_COND_GE,
    FXV_COND_GT,
    FXV_COND_LE,
    FXV_COND_ALWAYS,
    FXV_COND_NEVER
  } Fxv_cond;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_WB
  } Permute_seq_state;

  // full is only ever set for a PACK/LEFT op still waiting on its RIGHT pass
  typedef struct packed {
    Permute_op                op;
    Permute_mode              mode;
    logic                     full;
    logic [2:0]               size;
    logic [C_ELEM_SIZE-1:0]   g;
    logic signed [4:0]        shift;
    logic [C_REG_ADDR_W-1:0]  dest;
  } Permute_uop;

endpackage
`default_nettype wire

// File: rtl/vector_permute_ctrl_if.sv
`default_nettype none
// =============================================================================
// Module : Vector_permute_ctrl_if -- control fields from sequencer to permute unit
// Rev    : 1.0  initial release
// =============================================================================
interface Vector_permute_ctrl_if
  import vector_permute_seq_pkg::*;
#(
  parameter int ELEM_SIZE = C_ELEM_SIZE
);

  Permute_op             op;
  logic [2:0]            size;
  logic [ELEM_SIZE-1:0]  g;
  logic signed [4:0]     shift;
  logic                  pack_upper;
  logic                  pack_lower;
  logic                  unpack_left;
  logic                  unpack_right;
  logic                  keep_res;

  modport ctrl (
    output op, size, g, shift, pack_upper, pack_lower, unpack_left, unpack_right, keep_res
  );

  modport unit (
    input op, size, g, shift, pack_upper, pack_lower, unpack_left, unpack_right, keep_res
  );

endinterface
`default_nettype wire

// File: rtl/vector_permute_seq.sv
`default_nettype none
// =============================================================================
// Module : vector_permute_seq -- issues permute micro-ops and hands results to writeback
// Rev    : 1.0  initial release
// =============================================================================
module vector_permute_seq
  import vector_permute_seq_pkg::*;
#(
  parameter int NUM_ELEMS  = C_NUM_ELEMS,
  parameter int ELEM_SIZE  = C_ELEM_SIZE,
  parameter int REG_ADDR_W = C_REG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  iss_valid,
  output logic                  iss_ready,
  input  Permute_op             iss_op,
  input  Permute_mode           iss_mode,
  input  logic                  iss_full,
  input  logic [2:0]            iss_size,
  input  logic [ELEM_SIZE-1:0]  iss_g,
  input  logic signed [4:0]     iss_shift,
  input  logic [REG_ADDR_W-1:0] iss_dest,
  Vector_permute_ctrl_if.ctrl   ctrl,
  output logic                  wb_valid,
  input  logic                  wb_ready,
  output logic [REG_ADDR_W-1:0] wb_dest,
  output logic                  busy
);

  // The op register is a package struct, so its widths pin the parameters.
  if (NUM_ELEMS != C_NUM_ELEMS || ELEM_SIZE != C_ELEM_SIZE || REG_ADDR_W != C_REG_ADDR_W)
  begin : g_param_check
    $error("vector_permute_seq: parameters must match vector_permute_seq_pkg");
  end

  localparam Permute_uop C_UOP_RESET = '{
    op: PERM_SPLAT, mode: MODE_UPPER, full: 1'b0, size: 3'd0, g: '0, shift: '0, dest: '0
  };

  Permute_seq_state r_state;
  Permute_uop       r_uop;
  Permute_uop       w_iss_uop;
  logic             w_accept;
  logic             w_second_pass;
  logic             w_is_pack;

  always_comb begin
    w_iss_uop = '{
      op:    iss_op,
      mode:  iss_mode,
      full:  iss_full && (iss_op == PERM_PACK) && (iss_mode == MODE_LEFT),
      size:  iss_size,
      g:     iss_g,
      shift: iss_shift,
      dest:  iss_dest
    };

    w_second_pass = (r_state == ST_WB) && r_uop.full;
    iss_ready     = reset && ((r_state == ST_IDLE) ||
                              ((r_state == ST_WB) && wb_ready && !w_second_pass));
    w_accept      = iss_valid && iss_ready;

    wb_valid = (r_state == ST_WB);
    wb_dest  = r_uop.dest;
    busy     = (r_state != ST_IDLE);

    // Fields follow the op register in every state; only keep_res is EXEC-gated.
    w_is_pack         = (r_uop.op == PERM_PACK);
    ctrl.op           = r_uop.op;
    ctrl.size         = r_uop.size;
    ctrl.g            = r_uop.g;
    ctrl.shift        = r_uop.shift;
    ctrl.pack_upper   = w_is_pack && (r_uop.mode == MODE_UPPER);
    ctrl.pack_lower   = w_is_pack && (r_uop.mode == MODE_LOWER);
    ctrl.unpack_left  = w_is_pack && (r_uop.mode == MODE_LEFT);
    ctrl.unpack_right = w_is_pack && (r_uop.mode == MODE_RIGHT);
    ctrl.keep_res     = (r_state == ST_EXEC);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_uop   <= C_UOP_RESET;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_uop   <= w_iss_uop;
            r_state <= ST_EXEC;
          end
        end
        ST_EXEC: r_state <= ST_WB;
        ST_WB: begin
          if (wb_ready) begin
            if (r_uop.full) begin
              r_uop.dest <= r_uop.dest + 1'b1;
              r_uop.mode <= MODE_RIGHT;
              r_uop.full <= 1'b0;
              r_state    <= ST_EXEC;
            end else if (w_accept) begin
              r_uop   <= w_iss_uop;
              r_state <= ST_EXEC;
            end else begin
              r_state <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vector_permute_seq.sv
`default_nettype none
// =============================================================================
// Module : tb_vector_permute_seq -- scoreboard bench for the permute sequencer
// Rev    : 1.0  initial release
// =============================================================================
module tb_vector_permute_seq;
  import vector_permute_seq_pkg::*;

  typedef struct {
    logic [2:0]  op;
    logic [2:0]  size;
    logic [15:0] g;
    logic [4:0]  shift;
    logic [3:0]  sel;   // {unpack_right, unpack_left, pack_lower, pack_upper}
    int          cyc;   // expected keep_res cycle, -1 when stall-dependent
  } exec_t;

  typedef struct {
    logic [4:0]  dest;
    bit          first; // first beat of a two-beat unpack
    logic [15:0] g;
  } wb_t;

  logic        clk;
  logic        reset;
  logic        iss_valid;
  logic        iss_ready;
  Permute_op   iss_op;
  Permute_mode iss_mode;
  logic        iss_full;
  logic [2:0]  iss_size;
  logic [15:0] iss_g;
  logic signed [4:0] iss_shift;
  logic [4:0]  iss_dest;
  logic        wb_valid;
  logic        wb_ready;
  logic [4:0]  wb_dest;
  logic        busy;

  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  bit    wb_rand = 0;
  bit    prev_keep = 0;
  int    last_accept = 0;
  exec_t exec_q[$];
  wb_t   wb_q[$];
  exec_t mon_e;
  wb_t   mon_w;

  Vector_permute_ctrl_if #(.ELEM_SIZE(16)) ctrl_if ();

  vector_permute_seq #(.NUM_ELEMS(8), .ELEM_SIZE(16), .REG_ADDR_W(5)) dut (
    .clk(clk), .reset(reset),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_op(iss_op), .iss_mode(iss_mode),
    .iss_full(iss_full), .iss_size(iss_size), .iss_g(iss_g), .iss_shift(iss_shift),
    .iss_dest(iss_dest), .ctrl(ctrl_if),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_dest(wb_dest), .busy(busy)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got time %0t required < 300000", $time);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [3:0] sel_of(input Permute_op op, input Permute_mode mode);
    return (op == PERM_PACK) ? 4'(1 << int'(mode)) : 4'b0000;
  endfunction

  // Reference: every accepted op yields one or two (EXEC, WB) passes.
  task automatic push_model(input Permute_op op, input Permute_mode mode, input bit full,
                            input logic [2:0] size, input logic [15:0] g,
                            input logic [4:0] shift, input logic [4:0] dest, input int c);
    bit    two;
    exec_t e;
    wb_t   w;
    two = (op == PERM_PACK) && (mode == MODE_LEFT) && full;
    e.op = op; e.size = size; e.g = g; e.shift = shift;
    e.sel = sel_of(op, mode); e.cyc = c;
    exec_q.push_back(e);
    w.dest = dest; w.first = two; w.g = g;
    wb_q.push_back(w);
    if (two) begin
      e.sel = sel_of(PERM_PACK, MODE_RIGHT); e.cyc = -1;
      exec_q.push_back(e);
      w.dest = 5'((int'(dest) + 1) % 32); w.first = 0;
      wb_q.push_back(w);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (wb_rand) wb_ready = ($urandom_range(0, 9) < 7);
  endtask

  task automatic offer(input Permute_op op, input Permute_mode mode, input bit full,
                       input logic [2:0] size, input logic [15:0] g,
                       input logic [4:0] shift, input logic [4:0] dest);
    iss_op = op; iss_mode = mode; iss_full = full; iss_size = size;
    iss_g = g; iss_shift = shift; iss_dest = dest; iss_valid = 1;
    for (int n = 0; n < 60; n++) begin
      #1;
      if (iss_ready) begin
        last_accept = cyc;
        push_model(op, mode, full, size, g, shift, dest, cyc + 1);
        tick();
        iss_valid = 0;
        return;
      end
      tick();
    end
    checks++; errors++;
    $display("FAIL accept_timeout: got no accept expected accept within 60 cycles");
    iss_valid = 0;
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_iss_ready"}, iss_ready, 0);
    chk({tag, "_wb_valid"}, wb_valid, 0);
    chk({tag, "_keep_res"}, ctrl_if.keep_res, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_wb_dest"}, wb_dest, 0);
    chk({tag, "_op"}, ctrl_if.op, PERM_SPLAT);
    chk({tag, "_g"}, ctrl_if.g, 0);
    chk({tag, "_sel"}, {ctrl_if.unpack_right, ctrl_if.unpack_left,
                        ctrl_if.pack_lower, ctrl_if.pack_upper}, 0);
  endtask

  // Monitor: samples mid-low-phase, after the driver has settled its inputs.
  always @(negedge clk) begin
    #2;
    if (!reset) begin
      prev_keep = 0;
    end else begin
      if (prev_keep) chk("wb_valid_after_exec", wb_valid, 1);
      prev_keep = ctrl_if.keep_res;
      if (ctrl_if.keep_res) begin
        chk("exec_no_wb_valid", wb_valid, 0);
        if (exec_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_keep_res: got keep_res=1 expected 0 (cycle %0d)", cyc);
        end else begin
          mon_e = exec_q.pop_front();
          chk("exec_op", ctrl_if.op, mon_e.op);
          chk("exec_size", ctrl_if.size, mon_e.size);
          chk("exec_g", ctrl_if.g, mon_e.g);
          chk("exec_shift", $unsigned(ctrl_if.shift), mon_e.shift);
          chk("exec_sel", {ctrl_if.unpack_right, ctrl_if.unpack_left,
                           ctrl_if.pack_lower, ctrl_if.pack_upper}, mon_e.sel);
          if (mon_e.cyc >= 0) chk("exec_cycle", cyc, mon_e.cyc);
        end
      end
      if (wb_valid) begin
        chk("wb_keep_res_low", ctrl_if.keep_res, 0);
        chk("wb_busy", busy, 1);
        if (wb_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_wb_valid: got wb_valid=1 expected 0 (cycle %0d)", cyc);
        end else begin
          mon_w = wb_q[0];
          chk("wb_dest", wb_dest, mon_w.dest);
          chk("wb_hold_g", ctrl_if.g, mon_w.g);
          if (mon_w.first) chk("wb_first_iss_ready", iss_ready, 0);
          else             chk("wb_iss_ready", iss_ready, wb_ready);
          if (wb_ready) void'(wb_q.pop_front());
        end
      end else if (!ctrl_if.keep_res) begin
        chk("idle_busy", busy, 0);
        chk("idle_iss_ready", iss_ready, 1);
      end
    end
  end

  initial begin
    int a1;
    int gap;
    Permute_op   rop;
    Permute_mode rmode;
    reset = 1; iss_valid = 0; iss_op = PERM_SPLAT; iss_mode = MODE_UPPER; iss_full = 0;
    iss_size = 0; iss_g = 0; iss_shift = 0; iss_dest = 0; wb_ready = 0;
    #1 reset = 0;
    tick();
    #1 reset_checks("por");
    tick();
    reset = 1;
    tick();

    // Single SPLAT, immediate writeback
    wb_ready = 1;
    offer(PERM_SPLAT, MODE_UPPER, 0, 3'd0, 16'hA5A5, 5'd0, 5'd3);
    repeat (3) tick();

    // PACK LOWER with four stalled writeback cycles
    wb_ready = 0;
    offer(PERM_PACK, MODE_LOWER, 0, 3'd2, 16'h1234, 5'd1, 5'd7);
    repeat (5) tick();
    wb_ready = 1;
    repeat (2) tick();

    // Full unpack at the top register wraps to register 0
    offer(PERM_PACK, MODE_LEFT, 1, 3'd3, 16'hBEEF, 5'h1E, 5'd31);
    repeat (5) tick();

    // Back-to-back issue during writeback
    offer(PERM_SPLATB, MODE_UPPER, 0, 3'd1, 16'h00FF, 5'd0, 5'd4);
    a1 = last_accept;
    offer(PERM_SHIFT, MODE_RIGHT, 1, 3'd0, 16'h0F0F, 5'd3, 5'd5);
    chk("b2b_spacing", last_accept - a1, 2);
    repeat (3) tick();

    // SELECT ignores full and carries the condition in size
    offer(PERM_SELECT, MODE_LEFT, 1, 3'(FXV_COND_GT), 16'h5555, 5'd2, 5'd10);
    #3 chk("select_size", ctrl_if.size, 3'(FXV_COND_GT));
    repeat (4) tick();

    // Reset during the first beat of a full unpack
    wb_ready = 0;
    offer(PERM_PACK, MODE_LEFT, 1, 3'd1, 16'hC3C3, 5'd4, 5'd9);
    tick();
    #5 reset = 0;
    #1 reset_checks("mid_reset");
    exec_q.delete();
    wb_q.delete();
    tick();
    tick();
    reset = 1;
    #1 chk("post_reset_iss_ready", iss_ready, 1);
    wb_ready = 1;
    repeat (4) tick();

    // Randomized traffic with random writeback backpressure
    wb_rand = 1;
    for (int i = 0; i < 80; i++) begin
      gap = $urandom_range(0, 2);
      repeat (gap) tick();
      rop   = ($urandom_range(0, 1) == 1) ? PERM_PACK : Permute_op'($urandom_range(0, 5));
      rmode = Permute_mode'($urandom_range(0, 3));
      offer(rop, rmode, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
            16'($urandom), 5'($urandom), 5'($urandom));
    end

    wb_rand = 0;
    wb_ready = 1;
    for (int n = 0; n < 100 && (exec_q.size() != 0 || wb_q.size() != 0); n++) tick();
    tick();
    #3;
    chk("drain_exec_q", exec_q.size(), 0);
    chk("drain_wb_q", wb_q.size(), 0);
    chk("drain_busy", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vector_permute_seq.md
Name: vector_permute_seq

Overview:
- Initiator side of the Vector_permute_ctrl_if control interface: accepts permute micro-ops from vector issue and drives the permute unit's control fields cycle by cycle.
- Times the permute unit's registered result (captured on keep_res) and hands it to vector register writeback with a dest address and valid/ready handshake.
- Sequences the two-pass "unpack full" compound op (unpack_left to dest, then unpack_right to dest+1).

Parameters:
- NUM_ELEMS, 8, vector elements; must match the permute unit.
- ELEM_SIZE, 16, element width in bits; must match the permute unit.
- REG_ADDR_W, 5, vector register address width.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- iss_valid  in  1  micro-op offered
- iss_ready  out  1  sequencer can accept
- iss_op  in  Vector::Permute_op  PACK/SPLAT/SPLATB/SHIFT/SHIFTB/SELECT
- iss_mode  in  Vector::Permute_mode (2)  UPPER/LOWER/LEFT/RIGHT; used only for PACK
- iss_full  in  1  two-pass unpack; honoured only for PACK with mode LEFT
- iss_size  in  3  pack sub-size, or Fxv_cond for SELECT
- iss_g  in  ELEM_SIZE  splat value
- iss_shift  in  5 (signed)  shift amount
- iss_dest  in  REG_ADDR_W  destination register
- ctrl  interface  Vector_permute_ctrl_if.ctrl  drives op, size, g, shift, pack_upper, pack_lower, unpack_left, unpack_right, keep_res
- wb_valid  out  1  permute y valid for writeback
- wb_ready  in  1  writeback accepts
- wb_dest  out  REG_ADDR_W  destination of the current result
- busy  out  1  state != IDLE

Behaviour:
- States: IDLE, EXEC, WB. Issue fields are latched into an op register on accept (iss_valid && iss_ready).
- IDLE: iss_ready=1. On accept, go to EXEC.
- EXEC (1 cycle):
  - ctrl fields are driven from the op register; keep_res=1, so the permute unit captures y at the end of the cycle.
  - For PACK, exactly one of pack_upper/pack_lower/unpack_left/unpack_right is high, per mode. All four are 0 for any other op.
  - Go to WB.
- WB:
  - wb_valid=1, wb_dest=latched dest; keep_res=0, so y holds stable under stall.
  - On wb_valid && wb_ready, for the first pass of a full unpack: dest <= dest+1 (mod 2^REG_ADDR_W), mode <= RIGHT, go to EXEC.
  - Otherwise go to IDLE. If iss_valid is high in the same cycle, accept it directly (iss_ready=1) and go to EXEC.
- iss_ready = (state==IDLE) || (state==WB && wb_ready && !second_pass_pending). Forced 0 while reset is low.
- Latency: accept at edge T → keep_res during cycle T+1 → wb_valid from cycle T+2. Peak throughput is 1 op per 2 cycles. A full unpack takes 2 WB beats.
- keep_res is 0 in every state except EXEC. Control fields are held (not X) outside EXEC.
- Reset (asynchronous, mid-operation included):
  - State returns to IDLE; any pending writeback or second pass is discarded.
  - wb_valid=0, keep_res=0, all pack selects 0, busy=0, wb_dest=0, op register cleared to SPLAT with g=0.
  - After reset, y content is don't-care until the next EXEC.
- iss_full with a non-PACK op, or with mode != LEFT, is ignored (single pass).
- Destination wrap: dest all-ones with full unpack writes its second pass to register 0.
- iss_* inputs are ignored while iss_ready=0; no assertion on them.

Decomposition:
- Vector package: add Permute_mode enum (UPPER, LOWER, LEFT, RIGHT) and Permute_seq_state enum (IDLE, EXEC, WB).
- Vector package: add a Permute_uop packed struct (op, mode, full, size, g, shift, dest) used for the op register.
- No sub-module; a single always_ff for state and op register plus one always_comb for ctrl and handshakes.

Test Plan:
- Reset release, then SPLAT g=16'hA5A5 dest=3 → keep_res high exactly in cycle T+1; wb_valid in T+2 with wb_dest=3; y equals 16'hA5A5 replicated.
- PACK mode LOWER size=2 with wb_ready held 0 for 4 cycles → wb_valid stays 1, keep_res stays 0, y unchanged; iss_ready=0 until the ready cycle.
- Full unpack (mode LEFT, full=1) dest=31 → two WB beats with wb_dest 31 then 0; second EXEC asserts unpack_right only; iss_ready=0 during the first WB.
- Back-to-back: second op offered during the first op's WB with wb_ready=1 → accepted that cycle; EXEC follows immediately, giving 2-cycle spacing.
- SELECT with iss_size=Fxv_cond_gt and iss_full=1 → single pass; all pack selects 0 and ctrl.size=gt.
- reset pulled low during WB of the first full-unpack pass → wb_valid and keep_res drop immediately; no second pass after release; iss_ready=1.
